apb_target_multi_timer: RTL and testbench
=========================================

APB_TARGET_MULTI_TIMER -- requirements
Module: apb_target_multi_timer

Interface
REQ-001 SHALL have parameter NUM_TIMERS, default 4, number of timer channels (legal 1..8).
REQ-002 SHALL have parameter COUNTER_WIDTH, default 32, channel counter/reload width in bits (legal 8..32).
REQ-003 SHALL have parameter PRESCALE_WIDTH, default 8, width of the shared prescaler in bits.
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 apb_request__paddr  input  32  APB address; only paddr[7:2] decoded.
REQ-007 apb_request__penable  input  1  APB access phase.
REQ-008 apb_request__psel  input  1  APB select.
REQ-009 apb_request__pwrite  input  1  1 = write.
REQ-010 apb_request__pwdata  input  32  write data.
REQ-011 apb_response__prdata  output  32  read data.
REQ-012 apb_response__pready  output  1  constant 1, zero wait states.
REQ-013 apb_response__perr  output  1  1 on access to an unimplemented channel or register.
REQ-014 timer_equalled  output  NUM_TIMERS  per-channel sticky expiry status.
REQ-015 irq  output  1  OR over channels of (status & irq_enable).

Function
REQ-016 An access SHALL occur when psel&&penable; a write when an access has pwrite=1; registers update on that edge.
REQ-017 Address map SHALL be: paddr[7:4] = channel c (0..NUM_TIMERS-1) or 15 (global); paddr[3:2] = register.
REQ-018 Per-channel registers SHALL be: 0x0 counter RW, 0x4 reload RW, 0x8 control RW ([0] enable, [1] periodic, [2] irq_enable), 0xC status ([0] equalled; read, write-1-to-clear).
REQ-019 Global registers SHALL be: 0xF0 prescale RW (PRESCALE_WIDTH bits), 0xF4 irq summary RO (status bits of all channels, bit c = channel c); 0xF8/0xFC read 0 with perr=1.
REQ-020 Writes SHALL truncate pwdata to the register width; reads SHALL zero-extend; prdata SHALL be 0 when no read access occurs.
REQ-021 Access to channel index >= NUM_TIMERS (not 15) SHALL return prdata=0, perr=1, no state change.
REQ-022 Shared prescaler SHALL down-count from prescale to 0, asserting a one-cycle tick on the cycle it is 0, then reload; prescale=0 SHALL tick every cycle.
REQ-023 A write to prescale SHALL also reload the prescaler count to the new value on the same edge.
REQ-024 On a tick with enable=1: counter != 0 SHALL decrement by 1; counter == 0 SHALL set status.
REQ-025 On expiry with periodic=1 the counter SHALL load reload; with periodic=0 enable SHALL clear and the counter SHALL stay 0.
REQ-026 With enable=0 the counter SHALL hold; status SHALL remain sticky until cleared.
REQ-027 APB write to counter or control SHALL take priority over a same-cycle tick update of that register.
REQ-028 A same-cycle expiry and write-1-to-clear of status SHALL leave status set (event wins).
REQ-029 timer_equalled and irq SHALL be registered-state derived, combinational from status/control, no extra latency.

Reset
REQ-030 On reset, counters, reloads, control, status, prescale and the prescaler count SHALL be 0; timer_equalled=0, irq=0, prdata=0, perr=0, pready=1.
REQ-031 Reset assertion mid-count SHALL clear state immediately, without waiting for clk.

Structure
REQ-032 A shared package SHALL hold the APB request/response structs, register offset constants, control bit positions and the global channel index (15).
REQ-033 A sub-module apb_timer_channel SHALL implement one channel (counter, reload, control, status, expiry logic), instantiated NUM_TIMERS times by generate.
REQ-034 Address decode, prescaler, read mux and irq reduction SHALL live in the top module.

Verification
REQ-035 prescale=0, ch0 reload=3, counter=3, control=0x3 -> status set after 4 ticks (cycle 4), counter reloads to 3, re-expires every 4 cycles.
REQ-036 prescale=2, ch1 counter=1, control=0x1 (one-shot) -> status set on 2nd tick (cycle 6), control reads 0x0, counter holds 0.
REQ-037 ch2 control=0x5, expire -> irq=1; write 0x1 to 0x2C -> irq=0 next cycle; clear coincident with new expiry -> status stays 1.
REQ-038 NUM_TIMERS=2: read 0x30 -> prdata=0, perr=1; read 0xF8 -> perr=1; write to 0x30 changes no register.
REQ-039 COUNTER_WIDTH=8: write 0x1FF to counter -> reads 0xFF; reset asserted mid-count -> all registers read 0, irq=0.

Source files
------------

// File: rtl/apb_target_multi_timer_pkg.sv
// Shared definitions for the APB multi-channel down-counting timer:
// bus structs, register map encodings and control bit positions.
package apb_target_multi_timer_pkg;

    typedef struct packed {
        logic [31:0] paddr;
        logic        penable;
        logic        psel;
        logic        pwrite;
        logic [31:0] pwdata;
    } apb_req_t;

    typedef struct packed {
        logic [31:0] prdata;
        logic        pready;
        logic        perr;
    } apb_rsp_t;

    // Per-channel register index, paddr[3:2]
    typedef enum logic [1:0] {
        REG_COUNTER = 2'd0,
        REG_RELOAD  = 2'd1,
        REG_CONTROL = 2'd2,
        REG_STATUS  = 2'd3
    } chan_reg_e;

    // Global register index, paddr[3:2] when paddr[7:4] == GLOBAL_CH
    typedef enum logic [1:0] {
        GREG_PRESCALE = 2'd0,
        GREG_IRQ_SUM  = 2'd1,
        GREG_RSVD0    = 2'd2,
        GREG_RSVD1    = 2'd3
    } glob_reg_e;

    localparam logic [3:0]  GLOBAL_CH     = 4'hF;

    localparam int unsigned CTRL_ENABLE   = 0;
    localparam int unsigned CTRL_PERIODIC = 1;
    localparam int unsigned CTRL_IRQ_EN   = 2;
    localparam int unsigned CTRL_WIDTH    = 3;

endpackage

// File: rtl/apb_target_multi_timer_channel.sv
// One timer channel: counter, reload, control and sticky status, advanced
// by the shared prescaler tick. Bus writes override same-cycle tick updates.
module apb_timer_channel
    import apb_target_multi_timer_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_tick,
    input  logic                     i_wr_counter,
    input  logic                     i_wr_reload,
    input  logic                     i_wr_control,
    input  logic                     i_clr_status,
    input  logic [COUNTER_WIDTH-1:0] i_wdata,
    output logic [COUNTER_WIDTH-1:0] o_counter,
    output logic [COUNTER_WIDTH-1:0] o_reload,
    output logic [CTRL_WIDTH-1:0]    o_control,
    output logic                     o_status
);

    logic [COUNTER_WIDTH-1:0] r_counter;
    logic [COUNTER_WIDTH-1:0] r_reload;
    logic [CTRL_WIDTH-1:0]    r_control;
    logic                     r_status;

    logic w_run;
    logic w_expire;
    logic w_periodic;

    assign w_run      = i_tick && r_control[CTRL_ENABLE];
    assign w_expire   = w_run && (r_counter == '0);
    assign w_periodic = r_control[CTRL_PERIODIC];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_counter <= '0;
        end else if (i_wr_counter) begin
            r_counter <= i_wdata;
        end else if (w_run) begin
            if (w_expire) begin
                r_counter <= w_periodic ? r_reload : '0;
            end else begin
                r_counter <= r_counter - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reload <= '0;
        end else if (i_wr_reload) begin
            r_reload <= i_wdata;
        end
    end

    // One-shot expiry drops enable unless software rewrites control this cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_control <= '0;
        end else if (i_wr_control) begin
            r_control <= i_wdata[CTRL_WIDTH-1:0];
        end else if (w_expire && !w_periodic) begin
            r_control[CTRL_ENABLE] <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_status <= 1'b0;
        end else if (w_expire) begin
            r_status <= 1'b1;
        end else if (i_clr_status) begin
            r_status <= 1'b0;
        end
    end

    assign o_counter = r_counter;
    assign o_reload  = r_reload;
    assign o_control = r_control;
    assign o_status  = r_status;

endmodule

// File: rtl/apb_target_multi_timer.sv
// APB target with NUM_TIMERS down-counting timer channels sharing one
// prescaler; zero-wait-state bus, sticky per-channel status and irq summary.
module apb_target_multi_timer
    import apb_target_multi_timer_pkg::*;
#(
    parameter int unsigned NUM_TIMERS     = 4,
    parameter int unsigned COUNTER_WIDTH  = 32,
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           apb_request__paddr,
    input  logic                  apb_request__penable,
    input  logic                  apb_request__psel,
    input  logic                  apb_request__pwrite,
    input  logic [31:0]           apb_request__pwdata,
    output logic [31:0]           apb_response__prdata,
    output logic                  apb_response__pready,
    output logic                  apb_response__perr,
    output logic [NUM_TIMERS-1:0] timer_equalled,
    output logic                  irq
);

    localparam logic [3:0] LAST_CH = 4'(NUM_TIMERS - 1);

    apb_req_t  w_req;
    apb_rsp_t  w_rsp;
    logic      w_access;
    logic      w_write;
    logic      w_read;
    logic [3:0] w_ch;
    chan_reg_e w_reg;
    glob_reg_e w_greg;
    logic      w_is_global;
    logic      w_ch_valid;
    logic      w_unused_bits;

    assign w_req = '{
        paddr:   apb_request__paddr,
        penable: apb_request__penable,
        psel:    apb_request__psel,
        pwrite:  apb_request__pwrite,
        pwdata:  apb_request__pwdata
    };

    assign w_access      = w_req.psel && w_req.penable;
    assign w_write       = w_access && w_req.pwrite;
    assign w_read        = w_access && !w_req.pwrite;
    assign w_ch          = w_req.paddr[7:4];
    assign w_reg         = chan_reg_e'(w_req.paddr[3:2]);
    assign w_greg        = glob_reg_e'(w_req.paddr[3:2]);
    assign w_is_global   = (w_ch == GLOBAL_CH);
    assign w_ch_valid    = (w_ch <= LAST_CH);
    assign w_unused_bits = ^{w_req.paddr[31:8], w_req.paddr[1:0], w_req.pwdata};

    // Shared prescaler
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [PRESCALE_WIDTH-1:0] r_presc_cnt;
    logic                      w_tick;
    logic                      w_wr_prescale;

    assign w_tick        = (r_presc_cnt == '0);
    assign w_wr_prescale = w_write && w_is_global && (w_greg == GREG_PRESCALE);

    // A prescale write restarts the count from the new value immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescale  <= '0;
            r_presc_cnt <= '0;
        end else if (w_wr_prescale) begin
            r_prescale  <= w_req.pwdata[PRESCALE_WIDTH-1:0];
            r_presc_cnt <= w_req.pwdata[PRESCALE_WIDTH-1:0];
        end else if (w_tick) begin
            r_presc_cnt <= r_prescale;
        end else begin
            r_presc_cnt <= r_presc_cnt - 1'b1;
        end
    end

    // Channels
    logic [COUNTER_WIDTH-1:0] w_counter [NUM_TIMERS];
    logic [COUNTER_WIDTH-1:0] w_reload  [NUM_TIMERS];
    logic [CTRL_WIDTH-1:0]    w_control [NUM_TIMERS];
    logic [NUM_TIMERS-1:0]    w_status;
    logic [NUM_TIMERS-1:0]    w_irq_en;

    for (genvar c = 0; c < NUM_TIMERS; c++) begin : g_ch
        logic w_sel;

        assign w_sel       = w_write && (w_ch == 4'(c));
        assign w_irq_en[c] = w_control[c][CTRL_IRQ_EN];

        apb_timer_channel #(
            .COUNTER_WIDTH(COUNTER_WIDTH)
        ) u_channel (
            .clk          (clk),
            .reset        (reset),
            .i_tick       (w_tick),
            .i_wr_counter (w_sel && (w_reg == REG_COUNTER)),
            .i_wr_reload  (w_sel && (w_reg == REG_RELOAD)),
            .i_wr_control (w_sel && (w_reg == REG_CONTROL)),
            .i_clr_status (w_sel && (w_reg == REG_STATUS) && w_req.pwdata[0]),
            .i_wdata      (w_req.pwdata[COUNTER_WIDTH-1:0]),
            .o_counter    (w_counter[c]),
            .o_reload     (w_reload[c]),
            .o_control    (w_control[c]),
            .o_status     (w_status[c])
        );
    end

    // Read mux
    logic [31:0] w_rd_data;
    logic        w_bad_addr;

    always_comb begin
        w_rd_data  = '0;
        w_bad_addr = 1'b0;
        if (w_is_global) begin
            case (w_greg)
                GREG_PRESCALE: w_rd_data[PRESCALE_WIDTH-1:0] = r_prescale;
                GREG_IRQ_SUM:  w_rd_data[NUM_TIMERS-1:0]     = w_status;
                default:       w_bad_addr = 1'b1;
            endcase
        end else if (w_ch_valid) begin
            for (int unsigned c = 0; c < NUM_TIMERS; c++) begin
                if (w_ch == 4'(c)) begin
                    case (w_reg)
                        REG_COUNTER: w_rd_data[COUNTER_WIDTH-1:0] = w_counter[c];
                        REG_RELOAD:  w_rd_data[COUNTER_WIDTH-1:0] = w_reload[c];
                        REG_CONTROL: w_rd_data[CTRL_WIDTH-1:0]    = w_control[c];
                        REG_STATUS:  w_rd_data[0]                 = w_status[c];
                        default:     w_rd_data = '0;
                    endcase
                end
            end
        end else begin
            w_bad_addr = 1'b1;
        end
    end

    always_comb begin
        w_rsp.prdata = w_read ? w_rd_data : '0;
        w_rsp.pready = 1'b1;
        w_rsp.perr   = w_access && w_bad_addr;
    end

    assign apb_response__prdata = w_rsp.prdata;
    assign apb_response__pready = w_rsp.pready;
    assign apb_response__perr   = w_rsp.perr;

    assign timer_equalled = w_status;
    assign irq            = |(w_status & w_irq_en);

endmodule

// File: tb/tb_apb_target_multi_timer.sv
// Scoreboard bench for apb_target_multi_timer: directed scenarios plus random
// APB traffic, checked against a cycle-level behavioural model of the timers.
module tb_apb_target_multi_timer;

    localparam int unsigned NT = 3;
    localparam int unsigned CW = 8;
    localparam int unsigned PW = 8;
    localparam logic [31:0] CMASK = 32'hFFFF_FFFF >> (32 - CW);
    localparam logic [31:0] PMASK = 32'hFFFF_FFFF >> (32 - PW);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   paddr = '0;
    logic [31:0]   pwdata = '0;
    logic          penable = 1'b0;
    logic          psel = 1'b0;
    logic          pwrite = 1'b0;
    logic [31:0]   prdata;
    logic          pready;
    logic          perr;
    logic [NT-1:0] teq;
    logic          irq;

    apb_target_multi_timer #(
        .NUM_TIMERS(NT),
        .COUNTER_WIDTH(CW),
        .PRESCALE_WIDTH(PW)
    ) dut (
        .clk                  (clk),
        .reset                (rst),
        .apb_request__paddr   (paddr),
        .apb_request__penable (penable),
        .apb_request__psel    (psel),
        .apb_request__pwrite  (pwrite),
        .apb_request__pwdata  (pwdata),
        .apb_response__prdata (prdata),
        .apb_response__pready (pready),
        .apb_response__perr   (perr),
        .timer_equalled       (teq),
        .irq                  (irq)
    );

    initial forever #5 clk = ~clk;

    // Reference model state
    logic [31:0]   m_cnt [NT];
    logic [31:0]   m_rel [NT];
    logic [31:0]   m_ctl [NT];
    logic [NT-1:0] m_st;
    logic [31:0]   m_pre;
    logic [31:0]   m_pcnt;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NT; c++) begin
            m_cnt[c] = '0;
            m_rel[c] = '0;
            m_ctl[c] = '0;
        end
        m_st   = '0;
        m_pre  = '0;
        m_pcnt = '0;
    endtask

    task automatic model_step();
        logic       wr;
        logic [3:0] ch;
        logic [1:0] rg;
        logic       tick;
        logic       run;
        logic       expd;
        wr   = psel && penable && pwrite;
        ch   = paddr[7:4];
        rg   = paddr[3:2];
        tick = (m_pcnt == 0);
        if (wr && ch == 4'hF && rg == 2'd0) begin
            m_pre  = pwdata & PMASK;
            m_pcnt = m_pre;
        end else if (tick) begin
            m_pcnt = m_pre;
        end else begin
            m_pcnt = m_pcnt - 1;
        end
        for (int c = 0; c < NT; c++) begin
            run  = tick && m_ctl[c][0];
            expd = run && (m_cnt[c] == 0);
            if (run) m_cnt[c] = expd ? (m_ctl[c][1] ? m_rel[c] : 32'd0) : m_cnt[c] - 1;
            if (expd && !m_ctl[c][1]) m_ctl[c][0] = 1'b0;
            if (wr && ch == 4'(c) && rg == 2'd3 && pwdata[0]) m_st[c] = 1'b0;
            if (expd) m_st[c] = 1'b1;
            if (wr && ch == 4'(c)) begin
                case (rg)
                    2'd0:    m_cnt[c] = pwdata & CMASK;
                    2'd1:    m_rel[c] = pwdata & CMASK;
                    2'd2:    m_ctl[c] = pwdata & 32'h7;
                    default: ;
                endcase
            end
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [3:0] ch;
        logic [1:0] rg;
        ch = a[7:4];
        rg = a[3:2];
        if (ch == 4'hF) begin
            if (rg == 2'd0) return m_pre;
            if (rg == 2'd1) return 32'(m_st);
            return 32'd0;
        end
        if (ch >= NT) return 32'd0;
        case (rg)
            2'd0:    return m_cnt[ch];
            2'd1:    return m_rel[ch];
            2'd2:    return m_ctl[ch];
            default: return 32'(m_st[ch]);
        endcase
    endfunction

    function automatic logic model_err(input logic [31:0] a);
        if (a[7:4] == 4'hF) return a[3:2] >= 2'd2;
        return a[7:4] >= NT;
    endfunction

    function automatic logic model_irq();
        for (int c = 0; c < NT; c++)
            if (m_st[c] && m_ctl[c][2]) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Monitor: sampled mid-cycle, away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check("timer_equalled", 32'(teq), 32'(m_st));
            check("irq", 32'(irq), 32'(model_irq()));
            if (psel && penable) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_access", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("prdata@%02h", e.addr[7:0]), prdata, e.data);
                    check($sformatf("perr@%02h", e.addr[7:0]), 32'(perr), 32'(e.err));
                    check("pready", 32'(pready), 32'd1);
                end
            end
        end
    end

    task automatic apb(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input bit use_const, input logic [31:0] cdata, input logic cerr);
        exp_t e;
        @(posedge clk); #2;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge clk); #2;
        penable = 1'b1;
        e.addr = a;
        if (use_const) begin
            e.data = cdata;
            e.err  = cerr;
        end else begin
            e.data = w ? 32'd0 : model_read(a);
            e.err  = model_err(a);
        end
        sb_q.push_back(e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        apb(1'b1, a, d, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a);
        apb(1'b0, a, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic rd_exp(input logic [31:0] a, input logic [31:0] d, input logic err);
        apb(1'b0, a, 32'd0, 1'b1, d, err);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #2;
            psel = 1'b0; penable = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]  ch;
        logic [1:0]  rg;
        logic [23:0] hi;
        logic [1:0]  lo;
        logic [31:0] d;
        logic        w;
        int unsigned r;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Reset values
        rd_exp(32'h00, 32'd0, 1'b0); rd_exp(32'h04, 32'd0, 1'b0);
        rd_exp(32'h08, 32'd0, 1'b0); rd_exp(32'h0C, 32'd0, 1'b0);
        rd_exp(32'h28, 32'd0, 1'b0); rd_exp(32'hF0, 32'd0, 1'b0);
        rd_exp(32'hF4, 32'd0, 1'b0);

        // Periodic ch0, prescale 0
        wr(32'hF0, 0); wr(32'h04, 3); wr(32'h00, 3); wr(32'h08, 3);
        idle(14);
        rd(32'h00); rd(32'h0C); rd_exp(32'h08, 32'h3, 1'b0); rd_exp(32'h04, 32'h3, 1'b0);
        wr(32'h08, 0); wr(32'h0C, 1); idle(2);
        rd_exp(32'h0C, 32'd0, 1'b0);

        // One-shot ch1, prescale 2
        wr(32'hF0, 2); wr(32'h10, 1); wr(32'h18, 1);
        idle(12);
        rd_exp(32'h18, 32'd0, 1'b0); rd_exp(32'h10, 32'd0, 1'b0); rd_exp(32'h1C, 32'd1, 1'b0);
        rd_exp(32'hF4, 32'h2, 1'b0); rd_exp(32'hF0, 32'h2, 1'b0);

        // ch2 irq, clear, clear coincident with expiry
        wr(32'hF0, 0); wr(32'h20, 2); wr(32'h28, 5);
        idle(6);
        check("irq_after_expiry", 32'(irq), 32'd1);
        wr(32'h2C, 1); idle(1);
        check("irq_after_clear", 32'(irq), 32'd0);
        wr(32'h24, 0); wr(32'h20, 0); wr(32'h28, 7); idle(2);
        wr(32'h2C, 1); idle(1);
        rd_exp(32'h2C, 32'd1, 1'b0);
        check("irq_clear_vs_expiry", 32'(irq), 32'd1);
        wr(32'h28, 0); wr(32'h2C, 1); idle(1);
        rd_exp(32'h2C, 32'd0, 1'b0);

        // Unimplemented channel / global registers
        rd_exp(32'h30, 32'd0, 1'b1); rd_exp(32'h34, 32'd0, 1'b1);
        rd_exp(32'hF8, 32'd0, 1'b1); rd_exp(32'hFC, 32'd0, 1'b1);
        wr(32'h30, 32'hFFFF_FFFF); wr(32'h38, 32'hFFFF_FFFF); wr(32'hF4, 32'hFFFF_FFFF);
        for (int i = 0; i < 12; i++) rd(32'(i * 4));
        rd(32'hF0); rd(32'hF4);

        // Width truncation and async reset mid-count
        wr(32'h00, 32'h1FF); rd_exp(32'h00, 32'hFF, 1'b0);
        wr(32'h04, 32'h155); rd_exp(32'h04, 32'h55, 1'b0);
        wr(32'hF0, 1); wr(32'h08, 3); wr(32'h28, 5);
        idle(5);
        check("irq_before_reset", 32'(irq), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("teq_async_reset", 32'(teq), 32'd0);
        check("irq_async_reset", 32'(irq), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        rd_exp(32'h00, 32'd0, 1'b0); rd_exp(32'h04, 32'd0, 1'b0);
        rd_exp(32'h08, 32'd0, 1'b0); rd_exp(32'h0C, 32'd0, 1'b0);
        rd_exp(32'h20, 32'd0, 1'b0); rd_exp(32'h28, 32'd0, 1'b0);
        rd_exp(32'hF0, 32'd0, 1'b0); rd_exp(32'hF4, 32'd0, 1'b0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       ch = 4'($urandom_range(0, NT - 1));
            else if (r == 8) ch = 4'hF;
            else             ch = 4'($urandom_range(NT, 14));
            rg = 2'($urandom_range(0, 3));
            hi = 24'($urandom);
            lo = 2'($urandom);
            w  = ($urandom_range(0, 99) < 60);
            d  = $urandom;
            if (ch == 4'hF && rg == 2'd0) d = $urandom_range(0, 3);
            else if (rg != 2'd2 && $urandom_range(0, 3) != 0)
                d = $urandom_range(0, 6) | ($urandom_range(0, 1) << 8);
            if (w) wr({hi, ch, rg, lo}, d);
            else rd({hi, ch, rg, lo});
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end
        idle(3);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
